// File: rtl/output_ctrl_if.sv
// Router output-port bundle: arbitration side (req/data/grant) and downstream link (send/data/receive).
// The controller takes the master view; the environment (input controllers + neighbour) the slave view.
interface output_ctrl_if #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_IN     = 4
);
  logic [NUM_IN-1:0]            req_in;
  logic [NUM_IN*DATA_WIDTH-1:0] data_in;
  logic [NUM_IN-1:0]            grant_out;
  logic                         receiveO;
  logic                         sendO;
  logic [DATA_WIDTH-1:0]        dataO;

  modport master (
    input  req_in, data_in, receiveO,
    output grant_out, sendO, dataO
  );

  modport slave (
    output req_in, data_in, receiveO,
    input  grant_out, sendO, dataO
  );
endinterface

// File: rtl/output_ctrl.sv
// Router output-port controller: round-robin arbitration into even/odd VC FIFOs,
// polarity selects which VC is written (P) and which drains to the neighbour (!P).

module output_ctrl_vcbuf #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head,
  output logic                  full,
  output logic                  empty
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DEPTH-1:0][DATA_WIDTH-1:0] mem_q, mem_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             empty_q, empty_d;

  // Full/empty come from the count; pointers only address storage.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push && (cnt_q != FULL_CNT)) begin
      for (int e = 0; e < DEPTH; e++)
        if (wr_ptr_q == PTR_W'(e)) mem_d[e] = push_data;
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
      cnt_d    = cnt_d + 1'b1;
    end
    if (pop && !empty_q) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
      cnt_d    = cnt_d - 1'b1;
    end
    empty_d = (cnt_d == '0);
  end

  always_comb begin
    head = '0;
    for (int e = 0; e < DEPTH; e++)
      if (rd_ptr_q == PTR_W'(e)) head = mem_q[e];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      empty_q  <= 1'b1;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      empty_q  <= empty_d;
    end
  end

  assign full  = (cnt_q == FULL_CNT);
  assign empty = empty_q;
endmodule

module output_ctrl #(
  parameter int DATA_WIDTH   = 64,
  parameter int BUFFER_DEPTH = 1,
  parameter int NUM_IN       = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          polarity,
  output_ctrl_if.master io,
  output logic [1:0]    vc_empty
);
  localparam int IDX_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_IN - 1);

  logic [1:0][IDX_W-1:0]            rr_ptr_q, rr_ptr_d;
  logic [1:0]                       push, pop, full, empty;
  logic [1:0][DATA_WIDTH-1:0]       head;
  logic [NUM_IN-1:0][DATA_WIDTH-1:0] din;
  logic [NUM_IN-1:0]                grant;
  logic [DATA_WIDTH-1:0]            win_data;
  logic [IDX_W-1:0]                 win_idx;
  logic [IDX_W-1:0]                 sel;
  logic                             win_vld;
  logic                             rd_vc;
  logic                             send;
  int                               idx;

  assign din   = io.data_in;
  assign rd_vc = ~polarity;

  // Scan from the write VC's own pointer; nothing is granted while that VC is full or in reset.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    sel     = '0;
    idx     = 0;
    if (!rst && !full[polarity]) begin
      for (int k = 0; k < NUM_IN; k++) begin
        idx = int'(rr_ptr_q[polarity]) + k;
        if (idx >= NUM_IN) idx = idx - NUM_IN;
        sel = IDX_W'(idx);
        if (!win_vld && io.req_in[sel]) begin
          win_vld = 1'b1;
          win_idx = sel;
        end
      end
    end
    grant    = win_vld ? (NUM_IN'(1) << win_idx) : '0;
    win_data = din[win_idx];
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (win_vld)
      rr_ptr_d[polarity] = (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rr_ptr_q <= '0;
    else     rr_ptr_q <= rr_ptr_d;
  end

  assign send = !rst && io.receiveO && !empty[rd_vc];

  always_comb begin
    for (int v = 0; v < 2; v++) begin
      push[v] = win_vld && (polarity == v[0]);
      pop[v]  = send && (rd_vc == v[0]);
    end
  end

  for (genvar v = 0; v < 2; v++) begin : g_vc
    output_ctrl_vcbuf #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (BUFFER_DEPTH)
    ) u_buf (
      .clk       (clk),
      .rst       (rst),
      .push      (push[v]),
      .push_data (win_data),
      .pop       (pop[v]),
      .head      (head[v]),
      .full      (full[v]),
      .empty     (empty[v])
    );
  end

  assign io.grant_out = grant;
  assign io.sendO     = send;
  assign io.dataO     = (!rst && !empty[rd_vc]) ? head[rd_vc] : '0;
  assign vc_empty     = empty;
endmodule
